// File: rtl/cdb_broadcaster_if.sv
// Handshake bundle between the functional units, the CDB broadcaster and the CDB consumers.
// The broadcaster takes the slave side; the FU/consumer environment takes the master side.
interface cdb_broadcaster_if #(
  parameter int NUM_FU = 4,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5
);
  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU-1:0]       fu_ready;
  logic [NUM_FU*TAG_W-1:0] fu_tag;
  logic [NUM_FU*XLEN-1:0]  fu_value;
  logic [NUM_FU-1:0]       fu_take_branch;
  logic [NUM_FU*XLEN-1:0]  fu_npc;

  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [XLEN-1:0]         cdb_value;
  logic                    cdb_take_branch;
  logic [XLEN-1:0]         cdb_npc;
  logic [NUM_FU-1:0]       cdb_grant;

  modport master (
    output fu_valid, fu_tag, fu_value, fu_take_branch, fu_npc,
    input  fu_ready,
    input  cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_npc, cdb_grant
  );

  modport slave (
    input  fu_valid, fu_tag, fu_value, fu_take_branch, fu_npc,
    output fu_ready,
    output cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_npc, cdb_grant
  );
endinterface

// File: rtl/cdb_broadcaster.sv
// Completion-stage CDB transmitter: per-FU result FIFOs feeding a round-robin arbiter
// that drives one registered CDB packet per cycle.
module cdb_broadcaster #(
  parameter int NUM_FU     = 4,
  parameter int XLEN       = 32,
  parameter int ROB_SIZE   = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            squash_signal,
  cdb_broadcaster_if.slave bus
);
  localparam int TAG_W = $clog2(ROB_SIZE);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
    logic             take_branch;
    logic [XLEN-1:0]  npc;
  } entry_t;

  entry_t            mem    [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr [NUM_FU];
  logic [PTR_W-1:0]  wr_ptr [NUM_FU];
  logic [CNT_W-1:0]  count  [NUM_FU];
  logic [RR_W-1:0]   rr_ptr;

  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic              found;
  logic [RR_W-1:0]   winner;
  logic [RR_W-1:0]   rr_next;
  entry_t            head;

  entry_t            cdb_q;
  logic              cdb_valid_q;
  logic [NUM_FU-1:0] cdb_grant_q;

  // Readiness looks only at registered counts, so fu_ready never depends on this cycle's arbitration.
  always_comb begin
    ready = '0;
    push  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      ready[i] = (count[i] != CNT_W'(FIFO_DEPTH));
      push[i]  = bus.fu_valid[i] && ready[i];
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_FU;
      if (!found && count[idx] != '0) begin
        found  = 1'b1;
        winner = RR_W'(idx);
      end
    end
    pop = '0;
    if (found) pop[winner] = 1'b1;
    rr_next = (int'(winner) == NUM_FU - 1) ? '0 : winner + 1'b1;
    head    = mem[winner][rd_ptr[winner]];
  end

  // NOTE: FIFO storage is not reset; count alone says which entries hold live data.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= '{tag:         bus.fu_tag[i*TAG_W +: TAG_W],
                               value:       bus.fu_value[i*XLEN +: XLEN],
                               take_branch: bus.fu_take_branch[i],
                               npc:         bus.fu_npc[i*XLEN +: XLEN]};
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_grant_q <= '0;
      cdb_q       <= '0;
    end else if (squash_signal) begin
      // rr_ptr and the data registers are deliberately left alone on a flush.
      for (int i = 0; i < NUM_FU; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      cdb_valid_q <= 1'b0;
      cdb_grant_q <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
      cdb_valid_q <= found;
      cdb_grant_q <= pop;
      if (found) begin
        cdb_q  <= head;
        rr_ptr <= rr_next;
      end
    end
  end

  assign bus.fu_ready        = ready;
  assign bus.cdb_valid       = cdb_valid_q;
  assign bus.cdb_grant       = cdb_grant_q;
  assign bus.cdb_tag         = cdb_q.tag;
  assign bus.cdb_value       = cdb_q.value;
  assign bus.cdb_take_branch = cdb_q.take_branch;
  assign bus.cdb_npc         = cdb_q.npc;
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: single result, simultaneous pushes, streaming,
// contention with backpressure, squash, and reset mid-operation.
module tb_cdb_broadcaster;
  localparam int NUM_FU     = 4;
  localparam int XLEN       = 32;
  localparam int ROB_SIZE   = 32;
  localparam int TAG_W      = 5;
  localparam int FIFO_DEPTH = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic squash_signal = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  cdb_broadcaster_if #(.NUM_FU(NUM_FU), .XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  cdb_broadcaster #(
    .NUM_FU(NUM_FU), .XLEN(XLEN), .ROB_SIZE(ROB_SIZE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .squash_signal(squash_signal),
    .bus          (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.fu_valid       = '0;
    bus.fu_tag         = '0;
    bus.fu_value       = '0;
    bus.fu_take_branch = '0;
    bus.fu_npc         = '0;
  endtask

  task automatic put(input int i, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v,
                     input logic b, input logic [XLEN-1:0] n);
    bus.fu_valid[i]                  = 1'b1;
    bus.fu_tag[i*TAG_W +: TAG_W]     = t;
    bus.fu_value[i*XLEN +: XLEN]     = v;
    bus.fu_take_branch[i]            = b;
    bus.fu_npc[i*XLEN +: XLEN]       = n;
  endtask

  task automatic reset_dut();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_valid"}, bus.cdb_valid, 0);
    check({pfx, "_grant"}, bus.cdb_grant, 0);
    check({pfx, "_tag"},   bus.cdb_tag, 0);
    check({pfx, "_value"}, bus.cdb_value, 0);
    check({pfx, "_tb"},    bus.cdb_take_branch, 0);
    check({pfx, "_npc"},   bus.cdb_npc, 0);
    check({pfx, "_ready"}, bus.fu_ready, 4'hf);
    check({pfx, "_rr"},    dut.rr_ptr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int q0[$];
    int q3[$];
    logic [TAG_W-1:0] t0, t3;
    logic [NUM_FU-1:0] exp_grant;
    bit drop0, drop3;
    int seen, accepted;

    idle();
    reset = 1'b1;
    step();
    step();
    check_reset_outputs("rst");
    reset = 1'b0;

    // Single result from FU2
    put(2, 5'd5, 32'h1234, 1'b1, 32'h40);
    step();
    idle();
    check("single_early_valid", bus.cdb_valid, 0);
    step();
    check("single_valid", bus.cdb_valid, 1);
    check("single_tag",   bus.cdb_tag, 5);
    check("single_value", bus.cdb_value, 32'h1234);
    check("single_npc",   bus.cdb_npc, 32'h40);
    check("single_tb",    bus.cdb_take_branch, 1);
    check("single_grant", bus.cdb_grant, 4'b0100);
    check("single_rr",    dut.rr_ptr, 3);
    step();
    check("single_once_valid", bus.cdb_valid, 0);
    check("single_once_grant", bus.cdb_grant, 0);

    // Simultaneous pushes from all FUs, starting from FU0 priority
    reset_dut();
    for (int i = 0; i < NUM_FU; i++) put(i, 5'(i + 1), 32'(100 + i), 1'b0, 32'(16 * i));
    step();
    idle();
    for (int i = 0; i < NUM_FU; i++) begin
      step();
      check("simul_valid", bus.cdb_valid, 1);
      check("simul_tag",   bus.cdb_tag, i + 1);
      check("simul_value", bus.cdb_value, 100 + i);
      check("simul_grant", bus.cdb_grant, 1 << i);
      check("simul_ready", bus.fu_ready, 4'hf);
    end
    step();
    check("simul_done_valid", bus.cdb_valid, 0);

    // Streaming from FU1: one result per cycle, fu_ready[1] never drops
    for (int c = 0; c < 12; c++) begin
      idle();
      if (c < 10) put(1, 5'(c), 32'(c * 3), 1'b0, 32'(c * 4));
      step();
      check("stream_ready1", bus.fu_ready[1], 1);
      if (c >= 1 && c <= 10) begin
        check("stream_valid", bus.cdb_valid, 1);
        check("stream_tag",   bus.cdb_tag, c - 1);
        check("stream_value", bus.cdb_value, (c - 1) * 3);
      end else begin
        check("stream_idle_valid", bus.cdb_valid, 0);
      end
    end

    // Contention between FU0 and FU3 with backpressure
    reset_dut();
    t0 = 5'd0;
    t3 = 5'd16;
    exp_grant = 4'b0001;
    drop0 = 1'b0;
    drop3 = 1'b0;
    seen = 0;
    accepted = 0;
    for (int c = 0; c < 24; c++) begin
      idle();
      if (c < 14) begin
        put(0, t0, 32'(t0), 1'b0, 32'h0);
        put(3, t3, 32'(t3), 1'b1, 32'h0);
        if (bus.fu_ready[0]) begin q0.push_back(int'(t0)); t0++; accepted++; end
        else drop0 = 1'b1;
        if (bus.fu_ready[3]) begin q3.push_back(int'(t3)); t3++; accepted++; end
        else drop3 = 1'b1;
      end
      step();
      if (bus.cdb_valid) begin
        seen++;
        check("cont_grant", bus.cdb_grant, exp_grant);
        exp_grant = (exp_grant == 4'b0001) ? 4'b1000 : 4'b0001;
        if (bus.cdb_grant == 4'b0001) begin
          check("cont_q0_nonempty", q0.size() != 0, 1);
          if (q0.size() != 0) check("cont_tag0", bus.cdb_tag, q0.pop_front());
        end else if (bus.cdb_grant == 4'b1000) begin
          check("cont_q3_nonempty", q3.size() != 0, 1);
          if (q3.size() != 0) check("cont_tag3", bus.cdb_tag, q3.pop_front());
        end
      end
    end
    check("cont_q0_drained", q0.size(), 0);
    check("cont_q3_drained", q3.size(), 0);
    check("cont_count", seen, accepted);
    check("cont_drop0", drop0, 1);
    check("cont_drop3", drop3, 1);

    // Squash while a broadcast is on the bus
    reset_dut();
    put(2, 5'd1, 32'h0, 1'b0, 32'h0);
    step();
    idle();
    step();
    step();
    check("sq_rr_setup", dut.rr_ptr, 3);
    put(3, 5'd14, 32'hE, 1'b0, 32'h0);
    put(0, 5'd10, 32'hA, 1'b0, 32'h0);
    put(2, 5'd12, 32'hC, 1'b0, 32'h0);
    step();
    idle();
    put(0, 5'd11, 32'hB, 1'b0, 32'h0);
    step();
    idle();
    check("sq_pre_valid", bus.cdb_valid, 1);
    check("sq_pre_tag",   bus.cdb_tag, 14);
    check("sq_pre_grant", bus.cdb_grant, 4'b1000);
    check("sq_pre_ready", bus.fu_ready, 4'b1110);
    squash_signal = 1'b1;
    step();
    squash_signal = 1'b0;
    check("sq_valid", bus.cdb_valid, 0);
    check("sq_grant", bus.cdb_grant, 0);
    check("sq_ready", bus.fu_ready, 4'hf);
    check("sq_rr",    dut.rr_ptr, 0);
    for (int c = 0; c < 6; c++) begin
      step();
      check("sq_quiet", bus.cdb_valid, 0);
    end

    // Reset mid-operation with full FIFOs and a packet on the bus
    for (int c = 0; c < 3; c++) begin
      idle();
      for (int i = 0; i < NUM_FU; i++) put(i, 5'(i * 8 + c), 32'(i), 1'b1, 32'h80);
      step();
    end
    check("rm_pre_valid", bus.cdb_valid, 1);
    check("rm_pre_grant", bus.cdb_grant, 4'b0010);
    check("rm_pre_tag",   bus.cdb_tag, 8);
    check("rm_pre_ready", bus.fu_ready, 4'b0010);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    check_reset_outputs("rm");
    step();
    check("rm_no_stale", bus.cdb_valid, 0);
    put(3, 5'd21, 32'hBEEF, 1'b0, 32'h100);
    step();
    idle();
    step();
    check("rm_fu3_valid", bus.cdb_valid, 1);
    check("rm_fu3_grant", bus.cdb_grant, 4'b1000);
    check("rm_fu3_tag",   bus.cdb_tag, 21);
    check("rm_fu3_value", bus.cdb_value, 32'hBEEF);
    step();
    put(1, 5'd3, 32'h3, 1'b0, 32'h0);
    put(3, 5'd4, 32'h4, 1'b0, 32'h0);
    step();
    idle();
    step();
    check("rm_order1_grant", bus.cdb_grant, 4'b0010);
    check("rm_order1_tag",   bus.cdb_tag, 3);
    step();
    check("rm_order2_grant", bus.cdb_grant, 4'b1000);
    check("rm_order2_tag",   bus.cdb_tag, 4);
    step();
    check("rm_end_valid", bus.cdb_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
